// File: rtl/mdu_unit.sv
// Multiply/divide unit holding the HI/LO pair: multi-cycle MULT(U)/DIV(U),
// single-edge MTHI/MTLO. Ports: clk, reset (sync, active-low), in1, in2,
// mdu_op, start -> busy, hi, lo.
module mdu_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  input  logic [2:0]  mdu_op,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = 16;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   hi_d, lo_d;

  logic        is_mul, is_div;
  logic        dz, ovf;
  logic [31:0] dsor;

  logic signed [63:0] sa, sb;
  logic [63:0]        prod_s, prod_u;
  logic signed [31:0] sq, sr;
  logic [31:0]        uq, ur;

  assign busy = (state_q == RUN);

  assign is_mul = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
  assign is_div = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);

  assign sa     = {{32{a_q[31]}}, a_q};
  assign sb     = {{32{b_q[31]}}, b_q};
  assign prod_s = sa * sb;
  assign prod_u = {32'h0, a_q} * {32'h0, b_q};

  // Divisor forced to 1 for /0 (result discarded) and for the
  // 0x80000000 / -1 overflow, where a/1 gives exactly the wanted
  // quotient 0x80000000 and remainder 0.
  assign dz   = (b_q == 32'h0);
  assign ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hffff_ffff);
  assign dsor = (dz || ovf) ? 32'd1 : b_q;
  assign sq   = $signed(a_q) / $signed(dsor);
  assign sr   = $signed(a_q) % $signed(dsor);
  assign uq   = a_q / dsor;
  assign ur   = a_q % dsor;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi;
    lo_d    = lo;
    if (state_q == IDLE) begin
      if (start) begin
        unique case (1'b1)
          is_mul: begin
            a_d     = in1;
            b_d     = in2;
            op_d    = mdu_op;
            cnt_d   = CW'(MUL_CYCLES);
            state_d = RUN;
          end
          is_div: begin
            a_d     = in1;
            b_d     = in2;
            op_d    = mdu_op;
            cnt_d   = CW'(DIV_CYCLES);
            state_d = RUN;
          end
          (mdu_op == OP_MTHI): hi_d = in1;
          (mdu_op == OP_MTLO): lo_d = in1;
          default: ;
        endcase
      end
    end else begin
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        cnt_d   = '0;
        case (op_q)
          OP_MULT:  {hi_d, lo_d} = prod_s;
          OP_MULTU: {hi_d, lo_d} = prod_u;
          OP_DIV: begin
            if (!dz) begin
              hi_d = sr;
              lo_d = sq;
            end
          end
          OP_DIVU: begin
            if (!dz) begin
              hi_d = ur;
              lo_d = uq;
            end
          end
          default: ;
        endcase
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi      <= hi_d;
      lo      <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: directed table, hand-written multi-cycle corner
// sequences and randomized ops against an arithmetic reference model.
module tb_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in1, in2;
  logic [2:0]  mdu_op;
  logic        start;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mdu_unit #(.MUL_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .in1(in1), .in2(in2),
    .mdu_op(mdu_op), .start(start), .busy(busy),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cyc;
    logic [31:0] ehi;
    logic [31:0] elo;
    string       name;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [2:0] op,
                                input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] h, inout logic [31:0] l,
                                output int c);
    longint      ps;
    logic [63:0] pu;
    int          ia, ib;
    ia = a;
    ib = b;
    c  = 0;
    case (op)
      3'd1: begin
        ps = longint'(ia) * longint'(ib);
        pu = ps;
        h  = pu[63:32];
        l  = pu[31:0];
        c  = MC;
      end
      3'd2: begin
        pu = {32'h0, a} * {32'h0, b};
        h  = pu[63:32];
        l  = pu[31:0];
        c  = MC;
      end
      3'd3: begin
        c = DC;
        if (b != 0) begin
          if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
            l = a;
            h = 0;
          end else begin
            l = ia / ib;
            h = ia % ib;
          end
        end
      end
      3'd4: begin
        c = DC;
        if (b != 0) begin
          l = a / b;
          h = a % b;
        end
      end
      3'd5: h = a;
      3'd6: l = a;
      default: ;
    endcase
  endfunction

  // Issue one op, scramble operands while busy, count busy cycles and
  // note whether hi/lo held their pre-operation values throughout.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int n,
                        output logic stable);
    logic [31:0] ph, pl;
    @(negedge clk);
    mdu_op = op;
    in1    = a;
    in2    = b;
    start  = 1'b1;
    ph     = hi;
    pl     = lo;
    @(negedge clk);
    start  = 1'b0;
    mdu_op = 3'd0;
    n      = 0;
    stable = 1'b1;
    while (busy && n < 200) begin
      if (hi !== ph || lo !== pl) stable = 1'b0;
      n++;
      in1 = $urandom;
      in2 = $urandom;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hffff_ffff;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic        st;
    logic [31:0] mh, ml;
    logic [2:0]  op;
    logic [31:0] a, b;
    int          c;

    tbl[0]  = '{3'd1, 32'hffff_fffe, 32'd3, MC,
                32'hffff_ffff, 32'hffff_fffa, "mult_neg"};
    tbl[1]  = '{3'd2, 32'hffff_ffff, 32'hffff_ffff, MC,
                32'hffff_fffe, 32'h0000_0001, "multu_max"};
    tbl[2]  = '{3'd3, 32'hffff_fff9, 32'd2, DC,
                32'hffff_ffff, 32'hffff_fffd, "div_neg"};
    tbl[3]  = '{3'd4, 32'd7, 32'd0, DC,
                32'hffff_ffff, 32'hffff_fffd, "divu_zero"};
    tbl[4]  = '{3'd3, 32'h8000_0000, 32'hffff_ffff, DC,
                32'h0, 32'h8000_0000, "div_ovf"};
    tbl[5]  = '{3'd5, 32'h1234, 32'h5, 0,
                32'h1234, 32'h8000_0000, "mthi"};
    tbl[6]  = '{3'd6, 32'ha5a5_a5a5, 32'h5, 0,
                32'h1234, 32'ha5a5_a5a5, "mtlo"};
    tbl[7]  = '{3'd0, 32'hdead_beef, 32'h1, 0,
                32'h1234, 32'ha5a5_a5a5, "none"};
    tbl[8]  = '{3'd7, 32'hdead_beef, 32'h1, 0,
                32'h1234, 32'ha5a5_a5a5, "rsvd"};
    tbl[9]  = '{3'd4, 32'd256, 32'd7, DC,
                32'd4, 32'd36, "divu"};
    tbl[10] = '{3'd3, 32'd7, 32'hffff_fffe, DC,
                32'd1, 32'hffff_fffd, "div_negdiv"};

    reset  = 1'b0;
    start  = 1'b0;
    mdu_op = 3'd0;
    in1    = 32'hffff_ffff;
    in2    = 32'hffff_ffff;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    reset = 1'b1;

    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, n, st);
      chk({tbl[i].name, "_cyc"}, 32'(n), 32'(tbl[i].cyc));
      chk({tbl[i].name, "_hi"}, hi, tbl[i].ehi);
      chk({tbl[i].name, "_lo"}, lo, tbl[i].elo);
      chk({tbl[i].name, "_stable"}, 32'(st), 32'd1);
    end

    // MTHI issued mid-MULT must vanish.
    do_reset();
    @(negedge clk);
    mdu_op = 3'd1;
    in1    = 32'hffff_fff9;
    in2    = 32'd6;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n     = 0;
    while (busy && n < 50) begin
      n++;
      if (n == 2) begin
        start  = 1'b1;
        mdu_op = 3'd5;
        in1    = 32'h1234;
      end else begin
        start  = 1'b0;
        mdu_op = 3'd0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("busy_mthi_cyc", 32'(n), 32'(MC));
    chk("busy_mthi_hi", hi, 32'hffff_ffff);
    chk("busy_mthi_lo", lo, 32'hffff_ffd6);
    @(negedge clk);
    chk("busy_mthi_late", hi, 32'hffff_ffff);

    // MTLO, then DIV aborted by reset in its fourth busy cycle.
    run_op(3'd6, 32'ha5a5_a5a5, 32'h0, n, st);
    chk("mtlo2_cyc", 32'(n), 32'd0);
    chk("mtlo2_lo", lo, 32'ha5a5_a5a5);
    @(negedge clk);
    mdu_op = 3'd3;
    in1    = 32'd100;
    in2    = 32'd3;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n     = 1;
    while (busy && n < 4) begin
      n++;
      @(negedge clk);
    end
    chk("abort_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'h0);
    chk("abort_lo", lo, 32'h0);
    repeat (DC) @(negedge clk);
    chk("abort_late_lo", lo, 32'h0);
    chk("abort_late_busy", 32'(busy), 32'd0);

    // Reset beats start on the same edge.
    @(negedge clk);
    reset  = 1'b0;
    start  = 1'b1;
    mdu_op = 3'd5;
    in1    = 32'hffff;
    @(negedge clk);
    chk("rst_vs_mthi", hi, 32'h0);
    mdu_op = 3'd1;
    @(negedge clk);
    chk("rst_vs_mult", 32'(busy), 32'd0);
    start  = 1'b0;
    reset  = 1'b1;

    // Randomized ops against the reference model.
    mh = 32'h0;
    ml = 32'h0;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick();
      b  = pick();
      model(op, a, b, mh, ml, c);
      run_op(op, a, b, n, st);
      chk("rnd_cyc", 32'(n), 32'(c));
      chk("rnd_hi", hi, mh);
      chk("rnd_lo", lo, ml);
      chk("rnd_stable", 32'(st), 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
